// File: rtl/seq_gen_serial_pkg.sv
// Shared definitions for the serial pattern generator: FSM state encoding
// (also used by the detector benches to decode state) and port-width helpers.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_GAP   = 2'b10,
      S_DONE  = 2'b11
   } state_e;

   localparam int REPS_W = 4;
   localparam int GAP_W  = 4;

   // len must be able to express WIDTH itself, hence the extra bit.
   function automatic int len_width(input int width);
      return $clog2(width) + 1;
   endfunction

   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/seq_gen_serial_piso_shift.sv
// Parallel-load pattern register with a bit-index counter; the selected bit
// is pattern[cnt], counting down from len-1 and reloading after bit 0.
module piso_shift #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   output logic             bit_out,
   output logic             last
);

   logic [WIDTH-1:0] pat_q, pat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] top_q, top_d;

   always_comb begin
      pat_d = pat_q;
      cnt_d = cnt_q;
      top_d = top_q;
      if (load) begin
         // len arrives already clamped to WIDTH, so len-1 fits the counter
         pat_d = pattern;
         cnt_d = CNT_W'(len - LEN_W'(1));
         top_d = CNT_W'(len - LEN_W'(1));
      end else if (shift) begin
         cnt_d = (cnt_q == '0) ? top_q : cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         top_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         top_q <= top_d;
      end
   end

   always_ff @(posedge clk) begin
      pat_q <= pat_d;
   end

   assign bit_out = pat_q[cnt_q];
   assign last    = (cnt_q == '0);

endmodule

// File: rtl/seq_gen_serial.sv
// Serial pattern generator: sends a captured pattern MSB-first, reps times,
// with GAP_CYCLES idle cycles between repetitions. All outputs are registered.
module seq_gen_serial
   import seq_gen_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [WIDTH-1:0]            pattern,
   input  logic [len_width(WIDTH)-1:0] len,
   input  logic [3:0]                  reps,
   output logic                        dout,
   output logic                        dout_valid,
   output logic                        busy,
   output logic                        done,
   output logic [1:0]                  state
);

   localparam int LEN_W = len_width(WIDTH);
   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [GAP_W-1:0] GAP_LAST =
      GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_e            state_q, state_d;
   logic [REPS_W-1:0] rep_q, rep_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              load, shift;
   logic              bit_out, last;
   logic [LEN_W-1:0]  len_eff;

   assign len_eff = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

   piso_shift #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W),
      .CNT_W (CNT_W)
   ) u_piso (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift   (shift),
      .pattern (pattern),
      .len     (len_eff),
      .bit_out (bit_out),
      .last    (last)
   );

   always_comb begin
      state_d = state_q;
      rep_d   = rep_q;
      gap_d   = gap_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load  = 1'b1;
               rep_d = (reps == 4'd0) ? 4'd0 : reps - 4'd1;
               if (len == '0 || reps == 4'd0) state_d = S_DONE;
               else                           state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shift = 1'b1;
            if (last) begin
               if (rep_q == 4'd0) begin
                  state_d = S_DONE;
               end else begin
                  rep_d = rep_q - 4'd1;
                  if (GAP_CYCLES == 0) begin
                     state_d = S_SHIFT;
                  end else begin
                     state_d = S_GAP;
                     gap_d   = GAP_LAST;
                  end
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) state_d = S_SHIFT;
            else             gap_d   = gap_q - GAP_W'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the current state, so they trail state by one cycle.
   always_comb begin
      dout_d       = (state_q == S_SHIFT) && bit_out;
      dout_valid_d = (state_q == S_SHIFT);
      busy_d       = (state_q != S_IDLE);
      done_d       = (state_q == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         rep_q        <= '0;
         gap_q        <= '0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rep_q        <= rep_d;
         gap_q        <= gap_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign state      = state_q;

endmodule
